// File: rtl/pre_if_stage_if.sv
// Instruction SRAM request/response bus between the pre-IF stage (master) and the
// instruction memory port (slave).
interface pre_if_stage_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok
    );
endinterface

// File: rtl/pre_if_stage.sv
// Pre-IF stage: next-PC selection and single-outstanding instruction fetch requests.
// Define PRE_IF_REDIRECT_BUF_EN to hold a redirect target until it is issued.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  if_allowin,
    input  logic [32:0]           id_if_bus,
    input  logic                  wb_ex,
    input  logic [31:0]           ex_entry,
    input  logic                  ertn_flush,
    input  logic [31:0]           ertn_entry,
    pre_if_stage_if.master        sram,
    output logic                  pf_if_valid,
    output logic [31:0]           pf_if_pc,
    output logic                  pf_if_cancel
);

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] redir_pc;
    logic [31:0] nextpc;
    logic        req;
    logic        hs;

    logic [31:0] pf_pc_q,     pf_pc_d;
    logic        out_cnt_q,   out_cnt_d;
    logic        cancel_q,    cancel_d;
`ifdef PRE_IF_REDIRECT_BUF_EN
    logic        buf_vld_q,   buf_vld_d;
    logic [31:0] buf_pc_q,    buf_pc_d;
`endif

    assign br_taken  = id_if_bus[32];
    assign br_target = id_if_bus[31:0];
    assign redirect  = wb_ex | ertn_flush | br_taken;
    assign redir_pc  = wb_ex      ? ex_entry   :
                       ertn_flush ? ertn_entry : br_target;

    // A live redirect always beats a buffered one; sequential +4 wraps naturally.
    always_comb begin
        nextpc = pf_pc_q + 32'd4;
`ifdef PRE_IF_REDIRECT_BUF_EN
        if (buf_vld_q) nextpc = buf_pc_q;
`endif
        if (redirect) nextpc = redir_pc;
    end

    // resetn gates req directly so the request drops the instant reset asserts.
    assign req = if_allowin & (~out_cnt_q | sram.inst_sram_data_ok) & resetn;
    assign hs  = req & sram.inst_sram_addr_ok;

    always_comb begin
        pf_pc_d   = hs ? nextpc : pf_pc_q;
        out_cnt_d = out_cnt_q;
        if (hs)                          out_cnt_d = 1'b1;
        else if (sram.inst_sram_data_ok) out_cnt_d = 1'b0;
        // Only an in-flight fetch whose data has not yet returned needs squashing.
        cancel_d = cancel_q;
        if (sram.inst_sram_data_ok)      cancel_d = 1'b0;
        else if (redirect && out_cnt_q)  cancel_d = 1'b1;
`ifdef PRE_IF_REDIRECT_BUF_EN
        buf_vld_d = buf_vld_q;
        buf_pc_d  = buf_pc_q;
        if (hs) begin
            buf_vld_d = 1'b0;
        end else if (redirect) begin
            buf_vld_d = 1'b1;
            buf_pc_d  = redir_pc;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pf_pc_q   <= RESET_PC;
            out_cnt_q <= 1'b0;
            cancel_q  <= 1'b0;
`ifdef PRE_IF_REDIRECT_BUF_EN
            buf_vld_q <= 1'b0;
            buf_pc_q  <= 32'd0;
`endif
        end else begin
            pf_pc_q   <= pf_pc_d;
            out_cnt_q <= out_cnt_d;
            cancel_q  <= cancel_d;
`ifdef PRE_IF_REDIRECT_BUF_EN
            buf_vld_q <= buf_vld_d;
            buf_pc_q  <= buf_pc_d;
`endif
        end
    end

    always_comb begin
        sram.inst_sram_req   = req;
        sram.inst_sram_wr    = 1'b0;
        sram.inst_sram_size  = 2'b10;
        sram.inst_sram_wstrb = 4'b0000;
        sram.inst_sram_addr  = nextpc;
        sram.inst_sram_wdata = 32'd0;
        pf_if_valid          = hs;
        pf_if_pc             = nextpc;
        pf_if_cancel         = cancel_q & resetn;
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed table-driven bench for pre_if_stage plus hand sequences for reset and wrap.
module tb_pre_if_stage;

    logic        clk;
    logic        resetn;
    logic        if_allowin;
    logic [32:0] id_if_bus;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] ertn_entry;
    logic        pf_if_valid;
    logic [31:0] pf_if_pc;
    logic        pf_if_cancel;

    int total = 0;
    int bad   = 0;

    pre_if_stage_if bus();

    pre_if_stage #(.RESET_PC(32'h1bfffffc)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .if_allowin   (if_allowin),
        .id_if_bus    (id_if_bus),
        .wb_ex        (wb_ex),
        .ex_entry     (ex_entry),
        .ertn_flush   (ertn_flush),
        .ertn_entry   (ertn_entry),
        .sram         (bus.master),
        .pf_if_valid  (pf_if_valid),
        .pf_if_pc     (pf_if_pc),
        .pf_if_cancel (pf_if_cancel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          alw;
        bit          br;
        logic [31:0] tgt;
        bit          ex;
        bit          ertn;
        bit          aok;
        bit          dok;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_vld;
        bit          e_cancel;
    } vec_t;

`ifdef PRE_IF_REDIRECT_BUF_EN
    localparam logic [31:0] JMP = 32'h1c000400;
`else
    localparam logic [31:0] JMP = 32'h1c000208;
`endif

    localparam int NV = 24;
    vec_t vec [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    initial begin
        //           alw br tgt            ex ertn aok dok  req addr             vld cancel
        vec[0]  = '{1, 0, 32'h0,          0, 0,   1,  0,   1, 32'h1c000000,    1, 0};
        vec[1]  = '{1, 0, 32'h0,          0, 0,   1,  1,   1, 32'h1c000004,    1, 0};
        vec[2]  = '{1, 0, 32'h0,          0, 0,   1,  1,   1, 32'h1c000008,    1, 0};
        vec[3]  = '{1, 0, 32'h0,          0, 0,   1,  0,   0, 32'h1c00000c,    0, 0};
        vec[4]  = '{1, 0, 32'h0,          0, 0,   1,  0,   0, 32'h1c00000c,    0, 0};
        vec[5]  = '{1, 0, 32'h0,          0, 0,   0,  1,   1, 32'h1c00000c,    0, 0};
        vec[6]  = '{1, 0, 32'h0,          0, 0,   1,  0,   1, 32'h1c00000c,    1, 0};
        vec[7]  = '{1, 1, 32'h1c000100,   0, 0,   1,  0,   0, 32'h1c000100,    0, 0};
        vec[8]  = '{1, 1, 32'h1c000100,   0, 0,   1,  0,   0, 32'h1c000100,    0, 1};
        vec[9]  = '{1, 1, 32'h1c000100,   0, 0,   1,  0,   0, 32'h1c000100,    0, 1};
        vec[10] = '{1, 1, 32'h1c000100,   0, 0,   1,  1,   1, 32'h1c000100,    1, 1};
        vec[11] = '{1, 0, 32'h0,          0, 0,   1,  1,   1, 32'h1c000104,    1, 0};
        vec[12] = '{1, 1, 32'h1c000100,   1, 0,   1,  1,   1, 32'h1c008000,    1, 0};
        vec[13] = '{1, 1, 32'h1c000300,   0, 1,   1,  1,   1, 32'h1c000200,    1, 0};
        vec[14] = '{1, 0, 32'h0,          0, 0,   1,  1,   1, 32'h1c000204,    1, 0};
        vec[15] = '{1, 1, 32'h1c000400,   0, 0,   0,  1,   1, 32'h1c000400,    0, 0};
        vec[16] = '{1, 0, 32'h0,          0, 0,   0,  0,   1, JMP,             0, 0};
        vec[17] = '{1, 0, 32'h0,          0, 0,   1,  0,   1, JMP,             1, 0};
        vec[18] = '{1, 0, 32'h0,          0, 0,   1,  1,   1, JMP + 32'd4,     1, 0};
        vec[19] = '{0, 0, 32'h0,          0, 0,   1,  1,   0, JMP + 32'd8,     0, 0};
        vec[20] = '{0, 0, 32'h0,          0, 0,   1,  0,   0, JMP + 32'd8,     0, 0};
        vec[21] = '{0, 0, 32'h0,          0, 0,   1,  0,   0, JMP + 32'd8,     0, 0};
        vec[22] = '{0, 0, 32'h0,          0, 0,   1,  0,   0, JMP + 32'd8,     0, 0};
        vec[23] = '{1, 0, 32'h0,          0, 0,   1,  0,   1, JMP + 32'd8,     1, 0};

        resetn = 1'b0;
        if_allowin = 1'b0;
        id_if_bus = '0;
        wb_ex = 1'b0;
        ex_entry = 32'h1c008000;
        ertn_flush = 1'b0;
        ertn_entry = 32'h1c000200;
        bus.inst_sram_addr_ok = 1'b0;
        bus.inst_sram_data_ok = 1'b0;

        #3;
        chk("rst_req",    0, {31'd0, bus.inst_sram_req}, 32'd0);
        chk("rst_valid",  0, {31'd0, pf_if_valid},       32'd0);
        chk("rst_cancel", 0, {31'd0, pf_if_cancel},      32'd0);
        chk("rst_wr",     0, {31'd0, bus.inst_sram_wr},  32'd0);
        chk("rst_size",   0, {30'd0, bus.inst_sram_size}, 32'd2);
        chk("rst_wstrb",  0, {28'd0, bus.inst_sram_wstrb}, 32'd0);
        chk("rst_wdata",  0, bus.inst_sram_wdata,        32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if_allowin = vec[i].alw;
            id_if_bus = {vec[i].br, vec[i].tgt};
            wb_ex = vec[i].ex;
            ertn_flush = vec[i].ertn;
            bus.inst_sram_addr_ok = vec[i].aok;
            bus.inst_sram_data_ok = vec[i].dok;
            #1;
            chk("req",    i, {31'd0, bus.inst_sram_req}, {31'd0, vec[i].e_req});
            chk("addr",   i, bus.inst_sram_addr,         vec[i].e_addr);
            chk("pc",     i, pf_if_pc,                   vec[i].e_addr);
            chk("valid",  i, {31'd0, pf_if_valid},       {31'd0, vec[i].e_vld});
            chk("cancel", i, {31'd0, pf_if_cancel},      {31'd0, vec[i].e_cancel});
        end

        // Squash the outstanding fetch, then pulse reset before its data returns.
        @(negedge clk);
        if_allowin = 1'b1;
        id_if_bus = {1'b1, 32'h1c000500};
        bus.inst_sram_addr_ok = 1'b1;
        bus.inst_sram_data_ok = 1'b0;
        #1;
        chk("pre_rst_cancel", 0, {31'd0, pf_if_cancel}, 32'd0);
        @(negedge clk);
        #1;
        chk("pre_rst_cancel", 1, {31'd0, pf_if_cancel}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_req",    0, {31'd0, bus.inst_sram_req}, 32'd0);
        chk("async_valid",  0, {31'd0, pf_if_valid},       32'd0);
        chk("async_cancel", 0, {31'd0, pf_if_cancel},      32'd0);
        bus.inst_sram_data_ok = 1'b1;
        #1;
        chk("held_req",     0, {31'd0, bus.inst_sram_req}, 32'd0);
        @(negedge clk);
        id_if_bus = '0;
        bus.inst_sram_data_ok = 1'b0;
        resetn = 1'b1;
        #1;
        chk("restart_req",    0, {31'd0, bus.inst_sram_req}, 32'd1);
        chk("restart_addr",   0, bus.inst_sram_addr,         32'h1c000000);
        chk("restart_valid",  0, {31'd0, pf_if_valid},       32'd1);
        chk("restart_cancel", 0, {31'd0, pf_if_cancel},      32'd0);

        // Exception entry at the top of the address space, then sequential wrap.
        @(negedge clk);
        wb_ex = 1'b1;
        ex_entry = 32'hfffffffc;
        bus.inst_sram_data_ok = 1'b1;
        #1;
        chk("wrap_ex_addr",  0, bus.inst_sram_addr, 32'hfffffffc);
        chk("wrap_ex_valid", 0, {31'd0, pf_if_valid}, 32'd1);
        @(negedge clk);
        wb_ex = 1'b0;
        #1;
        chk("wrap_addr",  0, bus.inst_sram_addr, 32'h00000000);
        chk("wrap_valid", 0, {31'd0, pf_if_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
